exmem_lsu: RTL and testbench

EXMEM_LSU -- requirements
Module: exmem_lsu

---
 rtl/exmem_lsu.sv | 152 +++++++++++++++
 tb/tb_exmem_lsu.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/exmem_lsu.sv
// rtl/exmem_lsu.sv - EX/MEM load/store unit: lane-select operand forwarding, dmem port and load-wait FSM.
// Optional stall-cycle performance counter enabled by defining EXMEM_LSU_PERF_EN.
module exmem_lsu #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rA_data,
  input  logic [DATA_W-1:0] rB_data,
  input  logic              fwd_rA,
  input  logic              fwd_rB,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [2:0]        wb_ppp,
  input  logic              wr_en,
  input  logic              mem_en,
  input  logic              mem_wr_en,
  input  logic [ADDR_W-1:0] imm_addr,
  input  logic              flush,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic              stall,
  output logic              rd_sel,
  output logic              busy
`ifdef EXMEM_LSU_PERF_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int H  = DATA_W / 2;
  localparam int NB = DATA_W / 8;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  logic [0:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] lane_mask;
  logic              is_load;
  logic              is_store;

  // Bit 0 is the MSB: "bits 0..H-1" is the upper half, byte 0 the most significant byte.
  always_comb begin
    lane_mask = '0;
    case (wb_ppp)
      3'b000: lane_mask = '1;
      3'b001: lane_mask = {{H{1'b1}}, {H{1'b0}}};
      3'b010: lane_mask = {{H{1'b0}}, {H{1'b1}}};
      3'b011: begin
        for (int b = 0; b < NB; b++) begin
          if ((b % 2) == 0) lane_mask[DATA_W-1-8*b -: 8] = 8'hFF;
        end
      end
      3'b100: begin
        for (int b = 0; b < NB; b++) begin
          if ((b % 2) == 1) lane_mask[DATA_W-1-8*b -: 8] = 8'hFF;
        end
      end
      default: lane_mask = '0;
    endcase
  end

  assign alu_a = fwd_rA ? ((rA_data & ~lane_mask) | (wb_data & lane_mask)) : rA_data;
  assign alu_b = fwd_rB ? ((rB_data & ~lane_mask) | (wb_data & lane_mask)) : rB_data;

  assign mem_wdata = alu_b;
  assign mem_addr  = imm_addr;

  assign is_load  = mem_en & wr_en & ~mem_wr_en;
  assign is_store = mem_en & mem_wr_en;

  // Reset is folded into the output decode so reset and flush give the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    rd_sel  = 1'b0;
    if (reset || flush) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_load) begin
            stall   = 1'b1;
            mem_req = 1'b1;
            rd_sel  = 1'b1;
            state_d = S_WAIT;
            cnt_d   = 4'd1;
          end else if (is_store) begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
          end
        end
        S_WAIT: begin
          mem_req = 1'b1;
          rd_sel  = 1'b1;
          if (cnt_q == LAT) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
          end else begin
            stall = 1'b1;
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == S_WAIT);

`ifdef EXMEM_LSU_PERF_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= 32'd0;
    end else if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
`else
  // Counter and port are absent in the default build.
`endif

endmodule

// File: tb/tb_exmem_lsu.sv
// tb/tb_exmem_lsu.sv - directed self-checking bench for exmem_lsu at MEM_LAT 1, 2 and 3.
module tb_exmem_lsu;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 16;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] rA_data, rB_data, wb_data;
  logic              fwd_rA, fwd_rB;
  logic [2:0]        wb_ppp;
  logic              wr_en, mem_en, mem_wr_en, flush;
  logic [ADDR_W-1:0] imm_addr;

  logic [DATA_W-1:0] alu_a_x [1:3];
  logic [DATA_W-1:0] alu_b_x [1:3];
  logic [ADDR_W-1:0] mem_addr_x [1:3];
  logic [DATA_W-1:0] mem_wdata_x [1:3];
  logic              mem_req_x [1:3];
  logic              mem_we_x [1:3];
  logic              stall_x [1:3];
  logic              rd_sel_x [1:3];
  logic              busy_x [1:3];
`ifdef EXMEM_LSU_PERF_EN
  logic [31:0]       stall_cycles_x [1:3];
`endif

  int checks   = 0;
  int failures = 0;

  for (genvar L = 1; L <= 3; L++) begin : g_dut
    exmem_lsu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(L)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .rA_data   (rA_data),
      .rB_data   (rB_data),
      .fwd_rA    (fwd_rA),
      .fwd_rB    (fwd_rB),
      .wb_data   (wb_data),
      .wb_ppp    (wb_ppp),
      .wr_en     (wr_en),
      .mem_en    (mem_en),
      .mem_wr_en (mem_wr_en),
      .imm_addr  (imm_addr),
      .flush     (flush),
      .alu_a     (alu_a_x[L]),
      .alu_b     (alu_b_x[L]),
      .mem_addr  (mem_addr_x[L]),
      .mem_wdata (mem_wdata_x[L]),
      .mem_req   (mem_req_x[L]),
      .mem_we    (mem_we_x[L]),
      .stall     (stall_x[L]),
      .rd_sel    (rd_sel_x[L]),
      .busy      (busy_x[L])
`ifdef EXMEM_LSU_PERF_EN
      ,
      .stall_cycles (stall_cycles_x[L])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    rA_data = '0; rB_data = '0; wb_data = '0;
    fwd_rA = 1'b0; fwd_rB = 1'b0; wb_ppp = 3'b111;
    wr_en = 1'b0; mem_en = 1'b0; mem_wr_en = 1'b0;
    imm_addr = '0; flush = 1'b0;
  endtask

  task automatic set_load();
    mem_en = 1'b1; wr_en = 1'b1; mem_wr_en = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_stall", stall_x[2], 1'b0);
    check("rst_busy", busy_x[2], 1'b0);
    check("rst_mem_req", mem_req_x[2], 1'b0);
    check("rst_mem_we", mem_we_x[2], 1'b0);
    check("rst_rd_sel", rd_sel_x[2], 1'b0);

    // Forwarding lane selects
    fwd_rA = 1'b1; rA_data = 64'h0; wb_data = 64'hFFFF_FFFF_FFFF_FFFF;
    wb_ppp = 3'b011; #1; check("fwd_even_bytes", alu_a_x[2], 64'hFF00_FF00_FF00_FF00);
    wb_ppp = 3'b110; #1; check("fwd_ppp110", alu_a_x[2], 64'h0);
    wb_ppp = 3'b100; #1; check("fwd_odd_bytes", alu_a_x[2], 64'h00FF_00FF_00FF_00FF);
    wb_ppp = 3'b001; #1; check("fwd_upper_half", alu_a_x[2], 64'hFFFF_FFFF_0000_0000);
    wb_ppp = 3'b000; #1; check("fwd_all", alu_a_x[2], 64'hFFFF_FFFF_FFFF_FFFF);
    rA_data = 64'h0123_4567_89AB_CDEF; fwd_rA = 1'b0; #1;
    check("fwd_off_passthru", alu_a_x[2], 64'h0123_4567_89AB_CDEF);
    idle_inputs();
    next_cycle();

    // Store with lower-half forward on rB
    do_reset();
    mem_en = 1'b1; mem_wr_en = 1'b1; fwd_rB = 1'b1; wb_ppp = 3'b010;
    rB_data = 64'h1111_1111_2222_2222; wb_data = 64'hAAAA_AAAA_BBBB_BBBB; imm_addr = 16'h1234;
    @(negedge clk);
    check("st_wdata", mem_wdata_x[2], 64'h1111_1111_BBBB_BBBB);
    check("st_alu_b", alu_b_x[2], 64'h1111_1111_BBBB_BBBB);
    check("st_addr", mem_addr_x[2], 16'h1234);
    check("st_we", mem_we_x[2], 1'b1);
    check("st_req", mem_req_x[2], 1'b1);
    check("st_stall", stall_x[2], 1'b0);
    check("st_rd_sel", rd_sel_x[2], 1'b0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("st_we_after", mem_we_x[2], 1'b0);
    check("st_busy_after", busy_x[2], 1'b0);
    next_cycle();

    // Load, MEM_LAT=2
    do_reset();
    set_load();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("ld2_stall_c%0d", c), stall_x[2], (c < 2) ? 1'b1 : 1'b0);
      check($sformatf("ld2_req_c%0d", c), mem_req_x[2], 1'b1);
      check($sformatf("ld2_rd_sel_c%0d", c), rd_sel_x[2], 1'b1);
      check($sformatf("ld2_we_c%0d", c), mem_we_x[2], 1'b0);
      check($sformatf("ld2_busy_c%0d", c), busy_x[2], (c == 0) ? 1'b0 : 1'b1);
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    check("ld2_idle_c3", busy_x[2], 1'b0);
    check("ld2_req_c3", mem_req_x[2], 1'b0);
`ifdef EXMEM_LSU_PERF_EN
    check("ld2_stall_cycles", stall_cycles_x[2], 32'd2);
`endif
    next_cycle();

    // Flush in cycle 2 of a load, MEM_LAT=3
    do_reset();
    set_load();
    next_cycle();
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    check("fl3_stall", stall_x[3], 1'b0);
    check("fl3_req", mem_req_x[3], 1'b0);
    check("fl3_rd_sel", rd_sel_x[3], 1'b0);
    check("fl3_we", mem_we_x[3], 1'b0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("fl3_busy_next", busy_x[3], 1'b0);
    check("fl3_req_next", mem_req_x[3], 1'b0);
    next_cycle();

    // Back-to-back loads, MEM_LAT=1
    do_reset();
    set_load();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("b2b1_stall_c%0d", c), stall_x[1], (c % 2 == 0) ? 1'b1 : 1'b0);
      check($sformatf("b2b1_req_c%0d", c), mem_req_x[1], 1'b1);
      next_cycle();
    end

    // Reset mid-WAIT, MEM_LAT=3
    do_reset();
    set_load();
    next_cycle();
    @(negedge clk);
    check("rw3_busy", busy_x[3], 1'b1);
    check("rw3_stall", stall_x[3], 1'b1);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("rw3_stall_after", stall_x[3], 1'b0);
    check("rw3_busy_after", busy_x[3], 1'b0);
    check("rw3_req_after", mem_req_x[3], 1'b0);
    next_cycle();
    @(negedge clk);
    check("rw3_req_later", mem_req_x[3], 1'b0);
    next_cycle();

    // Reset and flush together during a load request
    set_load();
    flush = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("rf_stall", stall_x[3], 1'b0);
    check("rf_req", mem_req_x[3], 1'b0);
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("rf_busy_next", busy_x[3], 1'b0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
